serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing A - B over WIDTH clock cycles, LSB first. It uses one full-subtractor bit cell and a registered borrow, the inverse arithmetic of the ripple full-adder datapath. It offers a start/busy/done handshake so a controller can issue subtractions on a narrow serial datapath. Results are held in output registers until the next operation completes.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
start  input  1  request a new subtraction; sampled only when busy=0.
a  input  WIDTH  minuend; captured in the cycle start is accepted.
b  input  WIDTH  subtrahend; captured in the cycle start is accepted.
busy  output  1  high while the serial operation runs.
done  output  1  one-cycle pulse; diff, bout and ovf are valid from this cycle onward.
diff  output  WIDTH  result A - B, modulo 2^WIDTH.
bout  output  1  final borrow; 1 when unsigned A < unsigned B.
ovf  output  1  signed overflow of A - B.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy=0, done=0, diff=0, bout=0, ovf=0. Operand and shift registers, borrow flop and bit counter are all cleared. Reset mid-operation abandons the operation and no done is emitted.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at a clk edge, do the following and go to RUN:
  - load a into shift register SA and b into SB;
  - clear the borrow flop and set the bit counter to 0;
  - latch a[WIDTH-1] and b[WIDTH-1] for the overflow computation.
- RUN, each cycle, for the bit cell with x=SA[0], y=SB[0], bin=borrow flop:
  - d = x ^ y ^ bin;
  - bo = (~x & y) | (~(x ^ y) & bin);
  - d shifts into the MSB of result register SR (shift right); SA and SB shift right;
  - the borrow flop takes bo; the counter increments.
- RUN exit: after exactly WIDTH RUN cycles (counter reaching WIDTH-1 on the final bit), go to DONE. On that same edge:
  - diff <= final SR value including the last bit;
  - bout <= final bo;
  - ovf <= (a_msb != b_msb) && (diff_msb != a_msb).
- busy=1 in every RUN cycle and 0 otherwise. start while busy=1 is ignored; a and b are don't-care.
- DONE: done=1 for exactly one cycle and busy=0. start=1 during DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted at edge k. busy is high for cycles k+1 .. k+WIDTH. done is high in cycle k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- diff, bout and ovf change only on the RUN→DONE edge or on reset. They are stable between completions and are unaffected by start or by operand changes.
- The output registers hold the previous result until the new result lands on the RUN→DONE edge.
- The counter must be wide enough to reach WIDTH-1 (clog2(WIDTH) bits, minimum 1). It does not wrap within an operation.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8: start with a=0x5A, b=0x3C.
  - Response: busy high 8 cycles, then done one cycle with diff=0x1E, bout=0, ovf=0.
- a=0x00, b=0x01 → diff=0xFF, bout=1, ovf=0.
- Overflow cases:
  - a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Back-to-back and ignored start:
  - Start a=0x10, b=0x01; pulse start again with a=0xFF, b=0xFF at RUN cycle 3 → ignored; result diff=0x0F.
  - Assert start with a=0x03, b=0x05 in the DONE cycle → next done exactly 9 cycles later with diff=0xFE, bout=1. diff holds 0x0F until then.
- Reset mid-operation:
  - Start a=0x22, b=0x11; assert rst asynchronously (between edges) at RUN cycle 4.
  - Response: busy, done, diff, bout and ovf go to 0 immediately; no done afterwards; a fresh start completes normally.
- Random regression, WIDTH=8 and WIDTH=16: ≥1000 random operand pairs.
  - Compare diff, bout and ovf against the reference model A-B.
  - Check the done cycle equals the start-accept edge plus WIDTH+1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a borrow flop
// process A - B LSB first over WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sr_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;
    logic             a_msb_r;
    logic             b_msb_r;

    logic             d_s;
    logic             bo_s;
    logic [WIDTH-1:0] sr_next_s;
    logic             last_s;

    function automatic logic fs_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    // Signed overflow only when operand signs differ and the result sign leaves the minuend's.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    // Bit cell on the current LSBs and the next value of the result shifter.
    always_comb begin
        d_s       = fs_diff(sa_r[0], sb_r[0], borrow_r);
        bo_s      = fs_borrow(sa_r[0], sb_r[0], borrow_r);
        sr_next_s = {d_s, sr_r[WIDTH-1:1]};
        last_s    = (cnt_r == CNT_LAST);
    end

    // Control FSM, serial datapath and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            sa_r     <= {WIDTH{1'b0}};
            sb_r     <= {WIDTH{1'b0}};
            sr_r     <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= {WIDTH{1'b0}};
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state_r)
                // DONE accepts start exactly like IDLE so operations can run back to back.
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa_r     <= a;
                        sb_r     <= b;
                        sr_r     <= {WIDTH{1'b0}};
                        borrow_r <= 1'b0;
                        cnt_r    <= {CW{1'b0}};
                        a_msb_r  <= a[WIDTH-1];
                        b_msb_r  <= b[WIDTH-1];
                        busy     <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sa_r     <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r     <= {1'b0, sb_r[WIDTH-1:1]};
                    sr_r     <= sr_next_s;
                    borrow_r <= bo_s;
                    if (last_s) begin
                        cnt_r   <= cnt_r;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        diff    <= sr_next_s;
                        bout    <= bo_s;
                        ovf     <= ovf_calc(a_msb_r, b_msb_r, sr_next_s[WIDTH-1]);
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed vectors plus random regression at WIDTH=8 and WIDTH=16
// against an arithmetic reference model of A - B.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = 8'h00, b8 = 8'h00;
    logic        busy8, done8, bout8, ovf8;
    logic [7:0]  diff8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic        busy16, done16, bout16, ovf16;
    logic [15:0] diff16;

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction
    function automatic logic [15:0] get_diff(input int w);
        return (w == 8) ? {8'h00, diff8} : diff16;
    endfunction
    function automatic logic get_bout(input int w);
        return (w == 8) ? bout8 : bout16;
    endfunction
    function automatic logic get_ovf(input int w);
        return (w == 8) ? ovf8 : ovf16;
    endfunction

    task automatic drive(input int w, input logic s, input logic [15:0] av, input logic [15:0] bv);
        if (w == 8) begin start8 = s; a8 = av[7:0]; b8 = bv[7:0]; end
        else begin start16 = s; a16 = av; b16 = bv; end
    endtask

    task automatic set_start(input int w, input logic s);
        if (w == 8) start8 = s;
        else start16 = s;
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic ref_sub(input int w, input logic [15:0] av, input logic [15:0] bv,
                           output logic [15:0] d, output logic bo, output logic ov);
        longint mask, half, ua, ub, sa, sb, sd;
        mask = (64'sd1 <<< w) - 64'sd1;
        half = 64'sd1 <<< (w - 1);
        ua = longint'(av) & mask;
        ub = longint'(bv) & mask;
        sa = (ua >= half) ? ua - (mask + 64'sd1) : ua;
        sb = (ub >= half) ? ub - (mask + 64'sd1) : ub;
        sd = sa - sb;
        d  = 16'((ua - ub) & mask);
        bo = (ua < ub);
        ov = (sd < -half) || (sd > half - 64'sd1);
    endtask

    // One operation, called just after a negedge; returns at the negedge where done is seen.
    // poke>0 pulses an (ignored) start with all-ones operands in that RUN cycle.
    task automatic op(input int w, input logic [15:0] av, input logic [15:0] bv, input int poke,
                      output logic [15:0] d_o, output logic bo_o, output logic ov_o);
        logic [15:0] ed, prev;
        logic        eb, eo, hold_ok;
        int          cycles, nbusy;
        ref_sub(w, av, bv, ed, eb, eo);
        prev    = get_diff(w);
        hold_ok = 1'b1;
        drive(w, 1'b1, av, bv);
        @(posedge clk);
        @(negedge clk);
        set_start(w, 1'b0);
        cycles = 1;
        nbusy  = 0;
        while (!get_done(w) && cycles <= w + 4) begin
            if (get_busy(w)) nbusy++;
            if (get_diff(w) !== prev) hold_ok = 1'b0;
            if (cycles == poke) drive(w, 1'b1, 16'hFFFF, 16'hFFFF);
            else set_start(w, 1'b0);
            @(negedge clk);
            cycles++;
        end
        set_start(w, 1'b0);
        check("done_seen", 64'(get_done(w)), 64'd1);
        check("latency", 64'(cycles), 64'(w + 1));
        check("busy_cycles", 64'(nbusy), 64'(w));
        check("busy_at_done", 64'(get_busy(w)), 64'd0);
        check("diff_hold", 64'(hold_ok), 64'd1);
        check("diff", 64'(get_diff(w)), 64'(ed));
        check("bout", 64'(get_bout(w)), 64'(eb));
        check("ovf", 64'(get_ovf(w)), 64'(eo));
        d_o  = get_diff(w);
        bo_o = get_bout(w);
        ov_o = get_ovf(w);
    endtask

    initial begin
        logic [15:0] d;
        logic        bo, ov;
        int          ndone;

        @(negedge clk);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_diff", 64'(diff8), 64'd0);
        check("rst_bout", 64'(bout8), 64'd0);
        check("rst_ovf", 64'(ovf8), 64'd0);
        check("rst_diff16", 64'(diff16), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        op(8, 16'h5A, 16'h3C, 0, d, bo, ov);
        check("v1_const", 64'({d[7:0], bo, ov}), 64'({8'h1E, 1'b0, 1'b0}));
        repeat (2) @(negedge clk);
        op(8, 16'h00, 16'h01, 0, d, bo, ov);
        check("v2_const", 64'({d[7:0], bo, ov}), 64'({8'hFF, 1'b1, 1'b0}));
        op(8, 16'h80, 16'h01, 0, d, bo, ov);
        check("v3_const", 64'({d[7:0], bo, ov}), 64'({8'h7F, 1'b0, 1'b1}));
        op(8, 16'h7F, 16'hFF, 0, d, bo, ov);
        check("v4_const", 64'({d[7:0], bo, ov}), 64'({8'h80, 1'b1, 1'b1}));

        repeat (3) @(negedge clk);
        op(8, 16'h10, 16'h01, 3, d, bo, ov);
        check("ign_start", 64'(d[7:0]), 64'h0F);
        op(8, 16'h03, 16'h05, 0, d, bo, ov);
        check("b2b_const", 64'({d[7:0], bo}), 64'({8'hFE, 1'b1}));

        // Asynchronous reset between edges in RUN cycle 4.
        @(negedge clk);
        drive(8, 1'b1, 16'h22, 16'h11);
        @(posedge clk);
        @(negedge clk);
        set_start(8, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_done", 64'(done8), 64'd0);
        check("mid_rst_out", 64'({diff8, bout8, ovf8}), 64'd0);
        #1 rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("no_done_after_rst", 64'(ndone), 64'd0);
        op(8, 16'h22, 16'h11, 0, d, bo, ov);
        check("post_rst_const", 64'({d[7:0], bo, ov}), 64'({8'h11, 1'b0, 1'b0}));

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3, 0) == 0) @(negedge clk);
            op(8, 16'($urandom_range(255, 0)), 16'($urandom_range(255, 0)), 0, d, bo, ov);
        end
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3, 0) == 0) @(negedge clk);
            op(16, 16'($urandom), 16'($urandom), 0, d, bo, ov);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
